// File: rtl/rps_pkg.sv
// rps_pkg: shared states, result codes, choice encodings and judging helpers
package rps_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARM, S_JUDGE, S_SHOW, S_OVER} state_t;
  localparam logic [1:0] RES_DRAW = 2'b00;
  localparam logic [1:0] RES_A = 2'b01;
  localparam logic [1:0] RES_B = 2'b10;
  localparam logic [2:0] ROCK = 3'b100;
  localparam logic [2:0] SCISSORS = 3'b010;
  localparam logic [2:0] PAPER = 3'b001;
  function automatic logic [1:0] onehot_to_idx(input logic [2:0] c);
    return c[2] ? 2'd0 : c[1] ? 2'd1 : 2'd2;
  endfunction
  function automatic logic beats(input logic [1:0] ia, input logic [1:0] ib);
    return (ia == 2'd0 && ib == 2'd1) || (ia == 2'd1 && ib == 2'd2) || (ia == 2'd2 && ib == 2'd0);
  endfunction
endpackage

// File: rtl/rps_match_ctrl_if.sv
// rps_match_ctrl_if: button pulses in, round/score/status display signals out
interface rps_match_ctrl_if #(parameter int SCORE_W = 4);
  logic ready;
  logic start;
  logic new_game;
  logic [2:0] btn_a;
  logic [2:0] btn_b;
  logic [2:0] choice_a;
  logic [2:0] choice_b;
  logic [3:0] key;
  logic armed;
  logic res_valid;
  logic [1:0] res_code;
  logic [SCORE_W-1:0] score_a;
  logic [SCORE_W-1:0] score_b;
  logic game_over;
  logic [1:0] winner;
  modport master (
    output ready, start, new_game, btn_a, btn_b,
    input choice_a, choice_b, key, armed, res_valid, res_code, score_a, score_b, game_over, winner
  );
  modport slave (
    input ready, start, new_game, btn_a, btn_b,
    output choice_a, choice_b, key, armed, res_valid, res_code, score_a, score_b, game_over, winner
  );
endinterface

// File: rtl/rps_choice_latch.sv
// rps_choice_latch: locks a player's first press, rock > scissors > paper on ties
module rps_choice_latch
  import rps_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic [2:0] btn,
  output logic [2:0] choice,
  output logic       locked
);
  assign locked = |choice;
  // capture only the first press of a round; clr wins over a same-cycle press
  always_ff @(posedge clk or negedge rst)
    if (!rst) choice <= '0;
    else if (clr) choice <= '0;
    else if (en && !locked && |btn) choice <= btn[2] ? ROCK : btn[1] ? SCISSORS : PAPER;
endmodule

// File: rtl/rps_match_ctrl.sv
// rps_match_ctrl: round FSM, choice timeout, judging and first-to-target scoring
module rps_match_ctrl
  import rps_pkg::*;
#(
  parameter int WIN_SCORE   = 3,
  parameter int SCORE_W     = 4,
  parameter int TIMEOUT_CYC = 0,
  parameter int TO_W        = 32
) (
  input logic clk,
  input logic rst,
  rps_match_ctrl_if.slave bus
);
  localparam logic [SCORE_W-1:0] WIN = SCORE_W'(WIN_SCORE);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC > 0 ? TIMEOUT_CYC - 1 : 0);
  state_t state, state_nx;
  logic [2:0] ca, cb;
  logic la, lb;
  logic [1:0] ia, ib;
  logic [TO_W-1:0] cnt;
  logic [SCORE_W-1:0] sa, sb, sa_nx, sb_nx;
  logic [1:0] res_q, judged;
  logic arm_go, timeout, clr;
  assign arm_go = (state == S_IDLE || state == S_SHOW) && bus.ready;
  assign timeout = (TIMEOUT_CYC > 0) && cnt == TO_LAST;
  assign clr = bus.new_game || arm_go;
  assign ia = onehot_to_idx(ca);
  assign ib = onehot_to_idx(cb);
  rps_choice_latch u_lat_a (.clk(clk), .rst(rst), .clr(clr), .en(state == S_ARM), .btn(bus.btn_a), .choice(ca), .locked(la));
  rps_choice_latch u_lat_b (.clk(clk), .rst(rst), .clr(clr), .en(state == S_ARM), .btn(bus.btn_b), .choice(cb), .locked(lb));
  // a missing player forfeits; nobody locked is a draw
  always_comb begin
    judged = RES_DRAW;
    if (la && lb) judged = (ia == ib) ? RES_DRAW : beats(ia, ib) ? RES_A : RES_B;
    else if (la) judged = RES_A;
    else if (lb) judged = RES_B;
  end
  assign sa_nx = (judged == RES_A && sa != WIN) ? sa + SCORE_W'(1) : sa;
  assign sb_nx = (judged == RES_B && sb != WIN) ? sb + SCORE_W'(1) : sb;
  // state register
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= S_IDLE;
    else state <= state_nx;
  // next state; new_game overrides everything including a judgement in flight
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE, S_SHOW: state_nx = bus.ready ? S_ARM : state;
      S_ARM: state_nx = ((bus.start && la && lb) || timeout) ? S_JUDGE : S_ARM;
      S_JUDGE: state_nx = (sa_nx == WIN || sb_nx == WIN) ? S_OVER : S_SHOW;
      S_OVER: state_nx = S_OVER;
      default: state_nx = S_IDLE;
    endcase
    if (bus.new_game) state_nx = S_IDLE;
  end
  // timeout counter, held result and scores
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      res_q <= RES_DRAW;
    end else if (bus.new_game) begin
      cnt <= '0;
      sa <= '0;
      sb <= '0;
      res_q <= RES_DRAW;
    end else begin
      cnt <= arm_go ? '0 : (state == S_ARM) ? cnt + TO_W'(1) : cnt;
      if (arm_go) res_q <= RES_DRAW;
      if (state == S_JUDGE) begin
        res_q <= judged;
        sa <= sa_nx;
        sb <= sb_nx;
      end
    end
  assign bus.choice_a = ca;
  assign bus.choice_b = cb;
  assign bus.key = (la && lb) ? {2'b00, ia} * 4'd3 + {2'b00, ib} + 4'd1 : 4'd0;
  assign bus.armed = state == S_ARM;
  assign bus.res_valid = state == S_JUDGE;
  assign bus.res_code = (state == S_JUDGE) ? judged : res_q;
  assign bus.score_a = sa;
  assign bus.score_b = sb;
  assign bus.game_over = state == S_OVER;
  assign bus.winner = (state != S_OVER) ? RES_DRAW : (sa == WIN) ? RES_A : RES_B;
endmodule

// File: tb/tb_rps_match_ctrl.sv
// tb_rps_match_ctrl: scoreboard bench for the match controller (target 3, timeout 10)
module tb_rps_match_ctrl;
  import rps_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int errors = 0;
  int ma = 0;
  int mb = 0;
  int n;
  logic [1:0] sb_q[$];
  always #5 clk = ~clk;
  rps_match_ctrl_if #(.SCORE_W(4)) bus ();
  rps_match_ctrl #(.WIN_SCORE(3), .SCORE_W(4), .TIMEOUT_CYC(10), .TO_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d exp %0d at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic idle_inputs();
    bus.ready = 0;
    bus.start = 0;
    bus.new_game = 0;
    bus.btn_a = '0;
    bus.btn_b = '0;
  endtask
  task automatic step();
    @(posedge clk);
    #1;
    idle_inputs();
  endtask
  task automatic after_judge();
    @(posedge clk);
    #1;
    chk("score_a", bus.score_a, ma);
    chk("score_b", bus.score_b, mb);
    chk("res_valid_pulse", bus.res_valid, 0);
    chk("game_over", bus.game_over, (ma == 3 || mb == 3));
  endtask
  task automatic play(input logic [2:0] a, input logic [2:0] b, input logic [1:0] exp);
    bus.ready = 1;
    step();
    bus.btn_a = a;
    bus.btn_b = b;
    step();
    sb_q.push_back(exp);
    bus.start = 1;
    step();
    @(negedge clk);
    chk("res_valid", bus.res_valid, 1);
    if (exp == RES_A && ma < 3) ma++;
    if (exp == RES_B && mb < 3) mb++;
    after_judge();
  endtask
  task automatic wait_judge(input int n0, output int cyc);
    cyc = n0;
    while (cyc < 30) begin
      @(negedge clk);
      if (bus.res_valid === 1'b1) break;
      cyc++;
    end
  endtask
  // pop the expected result whenever the DUT reports one
  always @(negedge clk)
    if (rst && bus.res_valid === 1'b1) begin
      chk("res_expected", sb_q.size() > 0, 1);
      if (sb_q.size() > 0) chk("res_code", bus.res_code, sb_q.pop_front());
    end
  initial begin
    idle_inputs();
    #12;
    chk("rst_choice_a", bus.choice_a, 0);
    chk("rst_key", bus.key, 0);
    chk("rst_score_a", bus.score_a, 0);
    chk("rst_score_b", bus.score_b, 0);
    chk("rst_res_code", bus.res_code, 0);
    chk("rst_res_valid", bus.res_valid, 0);
    chk("rst_armed", bus.armed, 0);
    chk("rst_over", {bus.game_over, bus.winner}, 0);
    @(posedge clk);
    #1 rst = 1;
    play(ROCK, SCISSORS, RES_A);
    chk("key_show", bus.key, 2);
    chk("armed_show", bus.armed, 0);
    bus.ready = 1;
    step();
    chk("armed", bus.armed, 1);
    bus.btn_a = PAPER;
    step();
    bus.btn_a = ROCK;
    step();
    bus.btn_b = PAPER;
    step();
    chk("first_lock", bus.choice_a, PAPER);
    chk("key_pp", bus.key, 9);
    sb_q.push_back(RES_DRAW);
    bus.start = 1;
    step();
    @(negedge clk);
    chk("res_valid", bus.res_valid, 1);
    after_judge();
    bus.ready = 1;
    step();
    bus.btn_a = 3'b110;
    step();
    chk("priority", bus.choice_a, ROCK);
    chk("key_half", bus.key, 0);
    bus.start = 1;
    step();
    @(negedge clk);
    chk("start_ignored", bus.res_valid, 0);
    chk("still_armed", bus.armed, 1);
    bus.btn_b = PAPER;
    step();
    sb_q.push_back(RES_B);
    bus.start = 1;
    step();
    @(negedge clk);
    chk("res_valid", bus.res_valid, 1);
    mb++;
    after_judge();
    bus.ready = 1;
    step();
    bus.btn_b = SCISSORS;
    step();
    sb_q.push_back(RES_B);
    wait_judge(1, n);
    chk("timeout_lat_b", n, 10);
    mb++;
    after_judge();
    chk("res_code_held", bus.res_code, RES_B);
    bus.ready = 1;
    step();
    chk("res_code_clr", bus.res_code, RES_DRAW);
    sb_q.push_back(RES_DRAW);
    wait_judge(0, n);
    chk("timeout_lat_none", n, 10);
    after_judge();
    play(SCISSORS, PAPER, RES_A);
    bus.ready = 1;
    step();
    bus.btn_a = ROCK;
    step();
    chk("lock_before_rst", bus.choice_a, ROCK);
    #2 rst = 0;
    #1;
    chk("arst_choice_a", bus.choice_a, 0);
    chk("arst_key", bus.key, 0);
    chk("arst_score_a", bus.score_a, 0);
    chk("arst_score_b", bus.score_b, 0);
    chk("arst_armed", bus.armed, 0);
    ma = 0;
    mb = 0;
    @(posedge clk);
    #1 rst = 1;
    play(PAPER, ROCK, RES_A);
    play(ROCK, SCISSORS, RES_A);
    play(SCISSORS, PAPER, RES_A);
    chk("winner", bus.winner, RES_A);
    bus.ready = 1;
    bus.start = 1;
    bus.btn_a = ROCK;
    bus.btn_b = ROCK;
    step();
    bus.ready = 1;
    step();
    chk("over_hold", bus.game_over, 1);
    chk("over_score", bus.score_a, 3);
    chk("over_armed", bus.armed, 0);
    chk("over_choice_b", bus.choice_b, PAPER);
    bus.new_game = 1;
    step();
    ma = 0;
    chk("ng_scores", {bus.score_a, bus.score_b}, 0);
    chk("ng_over", {bus.game_over, bus.winner}, 0);
    bus.ready = 1;
    step();
    bus.btn_a = ROCK;
    bus.btn_b = SCISSORS;
    step();
    sb_q.push_back(RES_A);
    bus.start = 1;
    step();
    bus.new_game = 1;
    step();
    @(posedge clk);
    #1;
    chk("ng_drop_score", bus.score_a, 0);
    chk("ng_choice", bus.choice_a, 0);
    chk("ng_state", bus.armed, 0);
    bus.ready = 1;
    bus.new_game = 1;
    step();
    chk("ng_over_ready", bus.armed, 0);
    chk("sb_drain", sb_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
